seesaw_i2c_target: RTL and testbench

//  I2C target (responder) speaking the seesaw register protocol: 7-bit address, 2-byte register
//  {module_base, function}, then data bytes. Counterpart of the on-chip I2C master. Serves as the

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_bus_sync.sv | 78 +++++++
 rtl/seesaw_i2c_target.sv | 222 ++++++++++++++++++++++
 tb/tb_seesaw_i2c_target.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the seesaw I2C target: FSM state encoding,
// seesaw NeoPixel register constants and the I2C acknowledge level.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_target_state_t;

  localparam logic [7:0] SEESAW_NEOPIXEL_BASE = 8'h0E;
  localparam logic [7:0] SEESAW_NEOPIXEL_BUF  = 8'h04;
  localparam logic [7:0] SEESAW_NEOPIXEL_SHOW = 8'h05;
  localparam logic       I2C_ACK              = 1'b0;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser and bus event detector (bit edges, START, STOP).
// Define I2C_GLITCH_FILTER_EN to add a 3-sample agreement filter after the synchroniser.
module i2c_bus_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_d;
  logic       r_sda_d;
  logic       w_scl;
  logic       w_sda;

  // Idle bus is high, so the pipeline resets to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_in};
      r_sda_sync <= {r_sda_sync[0], sda_in};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] r_scl_hist;
  logic [1:0] r_sda_hist;
  logic       r_scl_f;
  logic       r_sda_f;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_hist <= 2'b11;
      r_sda_hist <= 2'b11;
      r_scl_f    <= 1'b1;
      r_sda_f    <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
      if ((r_scl_sync[1] == r_scl_hist[0]) && (r_scl_hist[0] == r_scl_hist[1]))
        r_scl_f <= r_scl_sync[1];
      if ((r_sda_sync[1] == r_sda_hist[0]) && (r_sda_hist[0] == r_sda_hist[1]))
        r_sda_f <= r_sda_sync[1];
    end
  end

  assign w_scl = r_scl_f;
  assign w_sda = r_sda_f;
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  assign scl_rise  = w_scl & ~r_scl_d;
  assign scl_fall  = ~w_scl & r_scl_d;
  assign start_det = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign stop_det  = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign sda_s     = w_sda;

endmodule

// File: rtl/seesaw_i2c_target.sv
// Seesaw-protocol I2C target: decodes {base,func} register bytes, emits write strobes
// and read requests to a host register file. Open-drain SDA only; SCL is never stretched.
module seesaw_i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDRESS = 7'h2E,
  parameter int         OFFSET_WIDTH   = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    scl_in,
  input  logic                    sda_in,
  output logic                    sda_oe,
  output logic                    wr_valid,
  output logic [15:0]             wr_reg,
  output logic [OFFSET_WIDTH-1:0] wr_offset,
  output logic [7:0]              wr_data,
  output logic                    rd_req,
  output logic [OFFSET_WIDTH-1:0] rd_offset,
  input  logic [7:0]              rd_data,
  output logic                    busy,
  output logic                    stop_pulse,
  output i2c_target_state_t       dbg_state
);

  localparam logic [OFFSET_WIDTH-1:0] OFS_ONE = OFFSET_WIDTH'(1);

  logic w_scl_rise, w_scl_fall, w_start_det, w_stop_det, w_sda_s;
  logic [7:0] w_byte;

  i2c_target_state_t       r_state;
  logic [7:0]              r_shift;
  logic [3:0]              r_bit_cnt;
  logic [1:0]              r_reg_phase;
  logic [1:0]              r_ld_cnt;
  logic                    r_rnw;
  logic                    r_mack;
  logic                    r_sda_oe;
  logic                    r_wr_valid;
  logic [15:0]             r_wr_reg;
  logic [OFFSET_WIDTH-1:0] r_wr_cnt;
  logic [OFFSET_WIDTH-1:0] r_wr_offset;
  logic [7:0]              r_wr_data;
  logic                    r_rd_req;
  logic [OFFSET_WIDTH-1:0] r_rd_offset;
  logic                    r_busy;
  logic                    r_stop_pulse;

  i2c_bus_sync u_bus_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start_det),
    .stop_det  (w_stop_det),
    .sda_s     (w_sda_s)
  );

  assign w_byte = {r_shift[6:0], w_sda_s};

  // Read handshake: rd_req is a one-clk request for {wr_reg, rd_offset}; the host must
  // present rd_data within 2 clk and hold it until the next rd_req. r_ld_cnt counts down
  // to the capture point, where bit 7 is put on the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= 8'h00;
      r_bit_cnt    <= 4'd0;
      r_reg_phase  <= 2'd0;
      r_ld_cnt     <= 2'd0;
      r_rnw        <= 1'b0;
      r_mack       <= 1'b1;
      r_sda_oe     <= 1'b0;
      r_wr_valid   <= 1'b0;
      r_wr_reg     <= 16'h0000;
      r_wr_cnt     <= '0;
      r_wr_offset  <= '0;
      r_wr_data    <= 8'h00;
      r_rd_req     <= 1'b0;
      r_rd_offset  <= '0;
      r_busy       <= 1'b0;
      r_stop_pulse <= 1'b0;
    end else begin
      r_wr_valid   <= 1'b0;
      r_rd_req     <= 1'b0;
      r_stop_pulse <= 1'b0;
      if (r_ld_cnt != 2'd0) begin
        r_ld_cnt <= r_ld_cnt - 2'd1;
        if (r_ld_cnt == 2'd1) begin
          r_shift  <= rd_data;
          r_sda_oe <= ~rd_data[7];
        end
      end
      if (w_stop_det) begin
        r_state      <= ST_IDLE;
        r_sda_oe     <= 1'b0;
        r_stop_pulse <= r_busy;
        r_busy       <= 1'b0;
        r_ld_cnt     <= 2'd0;
      end else if (w_start_det) begin
        r_state     <= ST_ADDR;
        r_sda_oe    <= 1'b0;
        r_busy      <= 1'b0;
        r_bit_cnt   <= 4'd0;
        r_reg_phase <= 2'd0;
        r_ld_cnt    <= 2'd0;
        r_wr_cnt    <= '0;
        r_wr_offset <= '0;
        r_rd_offset <= '0;
      end else begin
        case (r_state)
          ST_ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
              r_bit_cnt <= 4'd0;
              if (r_shift[7:1] == DEVICE_ADDRESS) begin
                r_state  <= ST_ADDR_ACK;
                r_sda_oe <= 1'b1;
                r_busy   <= 1'b1;
                r_rnw    <= r_shift[0];
              end else begin
                r_state <= ST_IGNORE;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b0;
              if (r_rnw) begin
                r_state  <= ST_RD_BYTE;
                r_rd_req <= 1'b1;
                r_ld_cnt <= 2'd2;
              end else begin
                r_state <= ST_WR_BYTE;
              end
            end
          end
          ST_WR_BYTE: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                case (r_reg_phase)
                  2'd0: begin
                    r_wr_reg[15:8] <= w_byte;
                    r_reg_phase    <= 2'd1;
                  end
                  2'd1: begin
                    r_wr_reg[7:0] <= w_byte;
                    r_reg_phase   <= 2'd2;
                  end
                  default: begin
                    r_wr_valid  <= 1'b1;
                    r_wr_data   <= w_byte;
                    r_wr_offset <= r_wr_cnt;
                    r_wr_cnt    <= r_wr_cnt + OFS_ONE;
                  end
                endcase
              end
            end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
              r_bit_cnt <= 4'd0;
              r_state   <= ST_WR_ACK;
              r_sda_oe  <= 1'b1;
            end
          end
          ST_WR_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b0;
              r_state  <= ST_WR_BYTE;
            end
          end
          ST_RD_BYTE: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_bit_cnt <= 4'd0;
                r_sda_oe  <= 1'b0;
                r_state   <= ST_RD_ACK;
              end else begin
                r_shift  <= {r_shift[6:0], 1'b0};
                r_sda_oe <= ~r_shift[6];
              end
            end
          end
          ST_RD_ACK: begin
            if (w_scl_rise) begin
              r_mack <= w_sda_s;
            end else if (w_scl_fall) begin
              if (r_mack == I2C_ACK) begin
                r_state     <= ST_RD_BYTE;
                r_rd_offset <= r_rd_offset + OFS_ONE;
                r_rd_req    <= 1'b1;
                r_ld_cnt    <= 2'd2;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= ST_IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe     = r_sda_oe;
  assign wr_valid   = r_wr_valid;
  assign wr_reg     = r_wr_reg;
  assign wr_offset  = r_wr_offset;
  assign wr_data    = r_wr_data;
  assign rd_req     = r_rd_req;
  assign rd_offset  = r_rd_offset;
  assign busy       = r_busy;
  assign stop_pulse = r_stop_pulse;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_seesaw_i2c_target.sv
// Bench for seesaw_i2c_target: bit-banged I2C master, host register-file model,
// table-driven write vectors, directed corner cases and randomized transactions.
module tb_seesaw_i2c_target;
  import i2c_pkg::*;

  localparam int         OW  = 6;
  localparam int         Q   = 60;
  localparam logic [6:0] DEV = 7'h2E;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic sda_line;
  logic sda_oe, wr_valid, rd_req, busy, stop_pulse;
  logic [15:0] wr_reg;
  logic [OW-1:0] wr_offset, rd_offset;
  logic [7:0] wr_data;
  logic [7:0] rd_data = 8'h00;
  i2c_target_state_t dbg_state;

  assign sda_line = m_sda & ~sda_oe;

  seesaw_i2c_target dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .scl_in     (m_scl),
    .sda_in     (sda_line),
    .sda_oe     (sda_oe),
    .wr_valid   (wr_valid),
    .wr_reg     (wr_reg),
    .wr_offset  (wr_offset),
    .wr_data    (wr_data),
    .rd_req     (rd_req),
    .rd_offset  (rd_offset),
    .rd_data    (rd_data),
    .busy       (busy),
    .stop_pulse (stop_pulse),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [29:0] exp_q[$];
  logic [21:0] exp_rd_q[$];
  logic [7:0]  rd_mem[64];
  logic [7:0]  tx_b[80];
  logic [15:0] m_reg = 16'h0000;
  int stop_cnt = 0, exp_stops = 0, wr_cnt = 0;
  bit saw_oe = 0, saw_busy = 0, saw_addr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (wr_valid) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL wr_extra: got %0h/%0h/%0h expected none", wr_reg, wr_offset, wr_data);
        end else begin
          check("wr_event", {wr_reg, wr_offset, wr_data}, exp_q.pop_front());
        end
      end
      if (rd_req) begin
        rd_data = rd_mem[rd_offset];
        if (exp_rd_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rd_extra: got %0h/%0h expected none", wr_reg, rd_offset);
        end else begin
          check("rd_req", {wr_reg, rd_offset}, exp_rd_q.pop_front());
        end
      end
      if (stop_pulse) stop_cnt++;
      if (sda_oe) saw_oe = 1;
      if (busy) saw_busy = 1;
      if (dbg_state == ST_ADDR) saw_addr = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_start();
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #(2*Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; #Q; m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #Q;
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; b = sda_line; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    for (int i = 7; i >= 0; i--) recv_bit(d[i]);
    send_bit(mack);
  endtask

  // Reference model: register bytes first, then data bytes indexed from 0 modulo 2**OW.
  task automatic do_write(input logic [6:0] addr, input int n, input bit do_stop);
    logic ack, exp_ack;
    bit match;
    match = (addr == DEV);
    exp_ack = match ? I2C_ACK : 1'b1;
    for (int i = 0; i < n; i++) begin
      if (match) begin
        if (i == 0) m_reg[15:8] = tx_b[i];
        else if (i == 1) m_reg[7:0] = tx_b[i];
        else exp_q.push_back({m_reg, 6'((i - 2) % 64), tx_b[i]});
      end
    end
    bus_start();
    write_byte({addr, 1'b0}, ack);
    check("addr_ack", ack, exp_ack);
    for (int i = 0; i < n; i++) begin
      write_byte(tx_b[i], ack);
      check("data_ack", ack, exp_ack);
    end
    if (do_stop) begin
      bus_stop();
      if (match) exp_stops++;
    end
  endtask

  task automatic do_read(input int n);
    logic ack;
    logic [7:0] d;
    for (int k = 0; k < n; k++) exp_rd_q.push_back({m_reg, 6'(k % 64)});
    bus_start();
    write_byte({DEV, 1'b1}, ack);
    check("rd_addr_ack", ack, I2C_ACK);
    for (int k = 0; k < n; k++) begin
      read_byte(d, (k == n - 1));
      check("rd_byte", d, rd_mem[k]);
    end
    check("sda_release", sda_oe, 1'b0);
    bus_stop();
    exp_stops++;
  endtask

  task automatic check_tail();
    check("wr_pending", exp_q.size(), 0);
    check("rd_pending", exp_rd_q.size(), 0);
    check("stop_cnt", stop_cnt, exp_stops);
    check("wr_reg", wr_reg, m_reg);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [6:0]      addr;
    int              n;
    logic [7:0][7:0] b;
    int              exp_wr;
    logic [15:0]     exp_reg;
    int              exp_stop;
    bit              exp_oe;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic ack;
    logic [6:0] a;
    int kind, n;

    vecs[0] = '{DEV, 7, {8'h00, 8'hFF, 8'h00, 8'h00, 8'h03, 8'h00, 8'h04, 8'h0E}, 5, 16'h0E04, 1, 1'b1};
    vecs[1] = '{7'h2F, 3, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33, 8'h22, 8'h11}, 0, 16'h0E04, 0, 1'b0};
    vecs[2] = '{DEV, 2, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h0E}, 0, 16'h0E05, 1, 1'b1};
    vecs[3] = '{DEV, 3, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7E, SEESAW_NEOPIXEL_SHOW,
                         SEESAW_NEOPIXEL_BASE}, 1, 16'h0E05, 1, 1'b1};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_wr_reg", wr_reg, 16'h0000);
    check("rst_rd_req", rd_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_stop_pulse", stop_pulse, 1'b0);
    check("rst_offsets", {wr_offset, rd_offset, wr_data}, 0);
    check("rst_state", dbg_state, ST_IDLE);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);

    // table-driven writes
    for (int v = 0; v < 4; v++) begin
      stop_cnt = 0; exp_stops = 0; wr_cnt = 0; saw_oe = 0; saw_busy = 0;
      for (int i = 0; i < vecs[v].n; i++) tx_b[i] = vecs[v].b[i];
      do_write(vecs[v].addr, vecs[v].n, 1'b1);
      check("vec_wr_cnt", wr_cnt, vecs[v].exp_wr);
      check("vec_wr_reg", wr_reg, vecs[v].exp_reg);
      check("vec_stop", stop_cnt, vecs[v].exp_stop);
      check("vec_oe", saw_oe, vecs[v].exp_oe);
      check("vec_busy", saw_busy, vecs[v].exp_oe);
      check_tail();
    end

    // set register then read back three bytes
    stop_cnt = 0; exp_stops = 0;
    tx_b[0] = 8'h00; tx_b[1] = 8'h01;
    do_write(DEV, 2, 1'b1);
    rd_mem[0] = 8'hA5; rd_mem[1] = 8'h5A; rd_mem[2] = 8'hC3;
    do_read(3);
    check_tail();

    // repeated START mid-byte drops the partial byte and restarts offsets
    wr_cnt = 0;
    tx_b[0] = SEESAW_NEOPIXEL_BASE; tx_b[1] = SEESAW_NEOPIXEL_BUF; tx_b[2] = 8'hAA;
    do_write(DEV, 3, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    tx_b[2] = 8'h11;
    do_write(DEV, 3, 1'b1);
    check("rstart_wr_cnt", wr_cnt, 2);
    check_tail();

    // data-byte offset wraps after all-ones
    for (int i = 0; i < 68; i++) tx_b[i] = (i < 2) ? 8'h0E : 8'($urandom_range(0, 255));
    tx_b[1] = SEESAW_NEOPIXEL_BUF;
    wr_cnt = 0;
    do_write(DEV, 68, 1'b1);
    check("wrap_wr_cnt", wr_cnt, 66);
    check_tail();

    // randomized transactions
    for (int t = 0; t < 10; t++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          a = 7'($urandom_range(0, 127));
          if (a == DEV) a = 7'h2F;
          n = $urandom_range(1, 4);
          for (int i = 0; i < n; i++) tx_b[i] = 8'($urandom_range(0, 255));
          do_write(a, n, 1'b1);
        end
        1: begin
          n = $urandom_range(2, 6);
          for (int i = 0; i < n; i++) tx_b[i] = 8'($urandom_range(0, 255));
          do_write(DEV, n, 1'b1);
        end
        default: begin
          tx_b[0] = 8'($urandom_range(0, 255)); tx_b[1] = 8'($urandom_range(0, 255));
          do_write(DEV, 2, (kind == 2));
          n = $urandom_range(1, 4);
          for (int k = 0; k < n; k++) rd_mem[k] = 8'($urandom_range(0, 255));
          do_read(n);
        end
      endcase
      check_tail();
    end

    // async reset while ACKing the address
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : DEV[i-1]);
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q;
    check("ack_driven", sda_oe, 1'b1);
    check("ack_busy", busy, 1'b1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_sda_oe", sda_oe, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    #20 reset_n = 1'b1;
    m_reg = 16'h0000;
    repeat (5) @(posedge clk);
    check("post_rst_state", dbg_state, ST_IDLE);
    check("post_rst_wr_reg", wr_reg, 16'h0000);

    // bus traffic without a START after reset is ignored
    saw_oe = 0; saw_busy = 0;
    m_scl = 1'b0; #Q;
    for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : DEV[i-1]);
    send_bit(1'b1);
    m_sda = 1'b1; #Q; m_scl = 1'b1; #(2*Q);
    check("no_start_oe", saw_oe, 1'b0);
    check("no_start_busy", saw_busy, 1'b0);

    // 1-clk SDA glitch while SCL high
    saw_addr = 0;
    @(negedge clk) m_sda = 1'b0;
    @(negedge clk) m_sda = 1'b1;
    repeat (12) @(negedge clk);
`ifdef I2C_GLITCH_FILTER_EN
    check("glitch_start", saw_addr, 1'b0);
`else
    check("glitch_start", saw_addr, 1'b1);
`endif
    check("glitch_state", dbg_state, ST_IDLE);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
